// File: rtl/instr_encoder_if.sv
// Field-bundle input, encoded-word output and address-load bus of instr_encoder.
// Handshake: a word moves across a port on any rising edge where valid && ready; valid never waits on ready.
interface instr_encoder_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_fmt;
  logic [6:0]    in_opcode;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [2:0]    in_funct3;
  logic [6:0]    in_funct7;
  logic [DW-1:0] in_imm;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_addr;
  logic          out_err;
  logic          addr_load;
  logic [AW-1:0] load_addr;
  logic [15:0]   err_cnt;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output out_ready, addr_load, load_addr,
    input  in_ready, out_valid, out_instr, out_addr, out_err, err_cnt
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  out_ready, addr_load, load_addr,
    output in_ready, out_valid, out_instr, out_addr, out_err, err_cnt
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32 instruction packer with a 2-entry output FIFO and a write-address counter.
// Define ENC_RANGE_CHECK_EN to flag out-of-range immediates and illegal formats (out_err / err_cnt).
module instr_encoder #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic             clk,
  input logic             rst,
  instr_encoder_if.slave  bus
);

  logic [DW-1:0] w_enc;
  logic          w_err;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_imm;

  logic [DW-1:0] r_mem_instr [2];
  logic [1:0]    r_mem_err;
  logic          r_wptr;
  logic          r_rptr;
  logic [1:0]    r_occ;
  logic [AW-1:0] r_addr;
  logic [15:0]   r_err_cnt;

  assign w_imm = bus.in_imm;

  always_comb begin
    w_enc = '0;
    case (bus.in_fmt)
      3'd0: w_enc = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
      3'd1: w_enc = {w_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
      3'd2: w_enc = {w_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, w_imm[4:0], bus.in_opcode};
      3'd3: w_enc = {w_imm[12], w_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                     w_imm[4:1], w_imm[11], bus.in_opcode};
      3'd4: w_enc = {w_imm[31:12], bus.in_rd, bus.in_opcode};
      3'd5: w_enc = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], bus.in_rd, bus.in_opcode};
      default: w_enc = '0;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // A value fits in N signed bits when every bit above N-2 equals the sign bit.
  logic w_fit12;
  logic w_fit13;
  logic w_fit21;
  assign w_fit12 = (w_imm[31:11] == {21{w_imm[31]}});
  assign w_fit13 = (w_imm[31:12] == {20{w_imm[31]}});
  assign w_fit21 = (w_imm[31:20] == {12{w_imm[31]}});

  always_comb begin
    w_err = 1'b0;
    case (bus.in_fmt)
      3'd1, 3'd2: w_err = !w_fit12;
      3'd3:       w_err = !w_fit13 || w_imm[0];
      3'd4:       w_err = (w_imm[11:0] != 12'd0);
      3'd5:       w_err = !w_fit21 || w_imm[0];
      3'd6, 3'd7: w_err = 1'b1;
      default:    w_err = 1'b0;
    endcase
  end
`else
  assign w_err = 1'b0;
`endif

  assign w_push = bus.in_valid && bus.in_ready;
  assign w_pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_instr[0] <= '0;
      r_mem_instr[1] <= '0;
      r_mem_err      <= '0;
      r_wptr         <= 1'b0;
      r_rptr         <= 1'b0;
      r_occ          <= 2'd0;
      r_addr         <= '0;
      r_err_cnt      <= '0;
    end else begin
      if (w_push) begin
        r_mem_instr[r_wptr] <= w_enc;
        r_mem_err[r_wptr]   <= w_err;
        r_wptr              <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
      // An explicit load wins over the post-transfer increment.
      if (bus.addr_load)  r_addr <= bus.load_addr;
      else if (w_pop)     r_addr <= r_addr + AW'(4);
`ifdef ENC_RANGE_CHECK_EN
      if (w_pop && r_mem_err[r_rptr] && (r_err_cnt != 16'hFFFF))
        r_err_cnt <= r_err_cnt + 16'd1;
`endif
    end
  end

  assign bus.in_ready  = (r_occ < 2'd2);
  assign bus.out_valid = (r_occ != 2'd0);
  assign bus.out_instr = r_mem_instr[r_rptr];
  assign bus.out_err   = r_mem_err[r_rptr];
  assign bus.out_addr  = r_addr;
  assign bus.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against a field-arithmetic reference model.
module tb_instr_encoder;

`ifdef ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  instr_encoder_if #(.AW(32), .DW(32)) bus ();

  instr_encoder #(.AW(32), .DW(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: {err, instr} per buffered word, plus address and error counters
  logic [32:0] exp_q[$];
  logic [31:0] m_addr;
  logic [15:0] m_cnt;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] ref_enc(input int fmt, input logic [31:0] op, input logic [31:0] rd,
                                          input logic [31:0] rs1, input logic [31:0] rs2,
                                          input logic [31:0] f3, input logic [31:0] f7,
                                          input logic [31:0] imm);
    logic [31:0] w;
    bit e;
    int s;
    s = imm;
    w = 32'd0;
    e = 1'b0;
    case (fmt)
      0: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      1: begin
        w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        e = (s < -2048) || (s > 2047);
      end
      2: begin
        w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
          | ((imm & 32'h1F) << 7) | op;
        e = (s < -2048) || (s > 2047);
      end
      3: begin
        w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
          | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | op;
        e = (s < -4096) || (s > 4095) || ((imm & 32'h1) != 0);
      end
      4: begin
        w = (imm & 32'hFFFF_F000) | (rd << 7) | op;
        e = (imm & 32'hFFF) != 0;
      end
      5: begin
        w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
          | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
        e = (s < -1048576) || (s > 1048575) || ((imm & 32'h1) != 0);
      end
      default: begin
        w = 32'd0;
        e = 1'b1;
      end
    endcase
    return {e & RC, w};
  endfunction

  // driver tasks
  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.in_fmt    = 3'd0;
    bus.in_opcode = 7'd0;
    bus.in_rd     = 5'd0;
    bus.in_rs1    = 5'd0;
    bus.in_rs2    = 5'd0;
    bus.in_funct3 = 3'd0;
    bus.in_funct7 = 7'd0;
    bus.in_imm    = 32'd0;
    bus.addr_load = 1'b0;
    bus.load_addr = 32'd0;
  endtask

  task automatic drive_bundle(input int fmt, input int op, input int rd, input int rs1, input int rs2,
                              input int f3, input int f7, input logic [31:0] imm);
    bus.in_valid  = 1'b1;
    bus.in_fmt    = 3'(fmt);
    bus.in_opcode = 7'(op);
    bus.in_rd     = 5'(rd);
    bus.in_rs1    = 5'(rs1);
    bus.in_rs2    = 5'(rs2);
    bus.in_funct3 = 3'(f3);
    bus.in_funct7 = 7'(f7);
    bus.in_imm    = imm;
  endtask

  // Checks outputs against the model, advances the model by one edge, returns at the next negedge.
  task automatic tick();
    bit push;
    bit pop;
    check("in_ready", bus.in_ready, exp_q.size() < 2);
    check("out_valid", bus.out_valid, exp_q.size() > 0);
    check("out_addr", bus.out_addr, m_addr);
    check("err_cnt", bus.err_cnt, m_cnt);
    if (exp_q.size() > 0) begin
      check("out_instr", bus.out_instr, exp_q[0][31:0]);
      check("out_err", bus.out_err, exp_q[0][32]);
    end
    if (rst) begin
      exp_q.delete();
      m_addr = 32'd0;
      m_cnt  = 16'd0;
    end else begin
      pop  = (exp_q.size() > 0) && bus.out_ready;
      push = bus.in_valid && (exp_q.size() < 2);
      if (bus.addr_load) m_addr = bus.load_addr;
      else if (pop)      m_addr = m_addr + 32'd4;
      if (pop) begin
        if (exp_q[0][32] && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        void'(exp_q.pop_front());
      end
      if (push)
        exp_q.push_back(ref_enc(int'(bus.in_fmt), 32'(bus.in_opcode), 32'(bus.in_rd), 32'(bus.in_rs1),
                                32'(bus.in_rs2), 32'(bus.in_funct3), 32'(bus.in_funct7), bus.in_imm));
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] imm;
    n_vec = 0;
    n_bad = 0;
    m_addr = 32'd0;
    m_cnt = 16'd0;
    rst = 1'b1;
    idle();
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_instr", bus.out_instr, 0);
    check("rst_out_err", bus.out_err, 0);
    check("rst_out_addr", bus.out_addr, 0);
    check("rst_err_cnt", bus.err_cnt, 0);

    // I-type addi x1, x0, 5
    drive_bundle(1, 'h13, 1, 0, 0, 0, 0, 32'd5);
    tick();
    idle();
    check("itype_valid", bus.out_valid, 1);
    check("itype_instr", bus.out_instr, 32'h0050_0093);
    bus.out_ready = 1'b1;
    tick();

    // B-type, offset -8
    bus.out_ready = 1'b0;
    drive_bundle(3, 'h63, 0, 1, 2, 0, 0, 32'hFFFF_FFF8);
    tick();
    idle();
    check("btype_instr", bus.out_instr, 32'hFE20_8CE3);
    bus.out_ready = 1'b1;
    tick();

    // J-type, offset 0x800
    bus.out_ready = 1'b0;
    drive_bundle(5, 'h6F, 1, 0, 0, 0, 0, 32'h800);
    tick();
    idle();
    check("jtype_instr", bus.out_instr, 32'h0010_00EF);
    bus.out_ready = 1'b1;
    tick();

    // backpressure: three offers into a stalled 2-entry buffer
    bus.out_ready = 1'b0;
    bus.addr_load = 1'b1;
    bus.load_addr = 32'h100;
    tick();
    idle();
    for (int i = 1; i <= 3; i++) begin
      drive_bundle(1, 'h13, 1, 0, 0, 0, 0, 32'(i));
      tick();
    end
    idle();
    check("bp_in_ready", bus.in_ready, 0);
    check("bp_addr0", bus.out_addr, 32'h100);
    check("bp_instr0", bus.out_instr, 32'h0010_0093);
    bus.out_ready = 1'b1;
    tick();
    check("bp_addr1", bus.out_addr, 32'h104);
    check("bp_instr1", bus.out_instr, 32'h0020_0093);
    tick();
    check("bp_drained", bus.out_valid, 0);

    // range: I-type immediate 2048
    bus.out_ready = 1'b0;
    drive_bundle(1, 'h13, 1, 0, 0, 0, 0, 32'd2048);
    tick();
    idle();
    check("range_instr", bus.out_instr, 32'h8000_0093);
    check("range_err", bus.out_err, RC);
    bus.out_ready = 1'b1;
    tick();
    check("range_cnt", bus.err_cnt, 16'(RC));

    // reset with two words buffered
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_bundle(0, 'h33, 3, 4, 5, 0, 32, 32'd0);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    check("mrst_out_valid", bus.out_valid, 0);
    check("mrst_out_addr", bus.out_addr, 0);
    check("mrst_in_ready", bus.in_ready, 1);
    tick();

    // address wrap
    bus.addr_load = 1'b1;
    bus.load_addr = 32'hFFFF_FFFC;
    tick();
    idle();
    drive_bundle(4, 'h37, 2, 0, 0, 0, 0, 32'h1234_5000);
    tick();
    idle();
    bus.out_ready = 1'b1;
    tick();
    check("wrap_addr", bus.out_addr, 32'h0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        1: imm = $urandom;
        2: imm = $urandom & 32'hFFFF_F000;
        default: imm = (32'($urandom_range(0, 32'h1F_FFFF)) - 32'h10_0000) & 32'hFFFF_FFFE;
      endcase
      drive_bundle(int'($urandom_range(0, 7)), int'($urandom_range(0, 127)), int'($urandom_range(0, 31)),
                   int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 127)), imm);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.addr_load = ($urandom_range(0, 29) == 0);
      bus.load_addr = $urandom;
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    idle();
    bus.out_ready = 1'b1;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter AW, default 32, address width of the write-address counter.
REQ-002 SHALL have parameter DW, default 32, instruction/immediate width (only 32 supported).
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1: field-bundle handshake.
REQ-006 SHALL have port in_fmt, input, 3, format code: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6/7 illegal.
REQ-007 SHALL have ports in_opcode input 7, in_rd input 5, in_rs1 input 5, in_rs2 input 5, in_funct3 input 3, in_funct7 input 7.
REQ-008 SHALL have port in_imm, input, DW, full signed immediate value (byte offset for B/J; U supplies final value with low 12 bits zero).
REQ-009 SHALL have ports out_valid output 1, out_ready input 1, out_instr output DW, out_addr output AW, out_err output 1.
REQ-010 SHALL have ports addr_load input 1, load_addr input AW: load the write-address counter.
REQ-011 SHALL have port err_cnt, output, 16, saturating count of flagged instructions.

Function
REQ-012 SHALL pack fields: R = funct7|rs2|rs1|funct3|rd|opcode; I = imm[11:0]|rs1|funct3|rd|opcode.
REQ-013 SHALL pack S = imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode; B = imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
REQ-014 SHALL pack U = imm[31:12]|rd|opcode; J = imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
REQ-015 SHALL encode illegal in_fmt as 32'h0000_0000.
REQ-016 SHALL buffer encoded words in a 2-entry FIFO; transfer occurs on valid&&ready at each port.
REQ-017 SHALL drive in_ready = (occupancy < 2), derived from registered state only.
REQ-018 SHALL present an accepted bundle on out_instr with out_valid high the cycle after acceptance (latency 1) when FIFO was empty.
REQ-019 SHALL hold out_instr/out_err/out_valid stable while out_valid && !out_ready.
REQ-020 SHALL preserve order; simultaneous push and pop at occupancy 1 keeps occupancy 1.
REQ-021 SHALL have out_addr show the address of the head entry; add 4 on each output transfer, wrapping modulo 2^AW.
REQ-022 SHALL, on addr_load, set out_addr to load_addr next cycle; load has priority over a simultaneous increment.

Reset
REQ-023 SHALL, on rst, clear occupancy, out_valid=0, out_instr=0, out_err=0, out_addr=0, err_cnt=0; in_ready=1 the following cycle.
REQ-024 SHALL discard buffered entries on rst asserted mid-operation; no transfer occurs in a reset cycle.

Configuration
REQ-025 SHALL gate range checking with macro ENC_RANGE_CHECK_EN.
REQ-026 SHALL, when defined, set out_err per entry if: I/S imm outside signed 12 bits; B outside signed 13 bits or imm[0]=1; J outside signed 21 bits or imm[0]=1; U imm[11:0]!=0; illegal fmt.
REQ-027 SHALL, when defined, increment err_cnt (saturating at 16'hFFFF) on each output transfer with out_err=1.
REQ-028 SHALL, when undefined, tie out_err and err_cnt to 0 and truncate immediates without flagging.

Verification
REQ-029 SHALL cover I-type: fmt=1, opcode 0x13, rd=1, rs1=0, funct3=0, imm=5 -> out_instr 0x00500093 one cycle later.
REQ-030 SHALL cover B-type: fmt=3, opcode 0x63, rs1=1, rs2=2, funct3=0, imm=-8 -> 0xFE208CE3; J-type: fmt=5, opcode 0x6F, rd=1, imm=0x800 -> 0x001000EF.
REQ-031 SHALL cover backpressure: addr_load 0x100, out_ready=0, offer 3 bundles -> 2 accepted, in_ready=0; release -> in-order output at out_addr 0x100, 0x104.
REQ-032 SHALL cover range: I-type imm=2048, rd=1, opcode 0x13 -> with macro out_err=1 and err_cnt=1 after transfer; without, out_instr 0x80000093 and out_err=0.
REQ-033 SHALL cover reset mid-operation: 2 entries buffered, rst for 1 cycle -> out_valid=0, out_addr=0, in_ready=1 next cycle.
REQ-034 SHALL cover wrap: load_addr 0xFFFFFFFC, one transfer -> out_addr 0x00000000.
